gpio_intr_ctrl: RTL
===================

GPIO_INTR_CTRL -- requirements
Module: gpio_intr_ctrl

Interface
REQ-001 SHALL provide parameter NPIN, default 32: number of GPIO pins.
REQ-002 SHALL provide parameter PRESC_W, default 16: debounce prescaler width.
REQ-003 SHALL provide port mclk  input  1  system clock; all state on rising edge.
REQ-004 SHALL provide port h_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port pad_gpio_in  input  NPIN  raw asynchronous pad inputs.
REQ-006 SHALL provide port cfg_deb_en  input  NPIN  per-pin debounce enable, 1=filtered.
REQ-007 SHALL provide port cfg_deb_presc  input  PRESC_W  debounce sample period minus one.
REQ-008 SHALL provide port cfg_posedge_sel  input  NPIN  rising-edge interrupt select.
REQ-009 SHALL provide port cfg_negedge_sel  input  NPIN  falling-edge interrupt select.
REQ-010 SHALL provide port cfg_int_mask  input  NPIN  interrupt enable, 1=enabled.
REQ-011 SHALL provide port sts_clr  input  NPIN  write-1-to-clear strobe, one cycle per write.
REQ-012 SHALL provide port gpio_data_in  output  NPIN  synchronised, optionally debounced pin value.
REQ-013 SHALL provide port gpio_int_sts  output  NPIN  sticky interrupt status.
REQ-014 SHALL provide port gpio_irq  output  1  registered interrupt request.

Function
REQ-015 SHALL pass each pad_gpio_in bit through a 2-flop synchroniser (sync1, sync2).
REQ-016 SHALL run one shared prescaler counter, 0..cfg_deb_presc; tick=1 when count>=cfg_deb_presc, counter then loads 0, else increments.
REQ-017 SHALL tick every cycle when cfg_deb_presc=0; a lowered cfg_deb_presc below current count SHALL yield a tick next cycle (>= compare), no lock-up.
REQ-018 SHALL, per pin on tick only, shift sync2 into a 2-bit history (h1<=sync2, h0<=h1).
REQ-019 SHALL, with cfg_deb_en[i]=1, update gpio_data_in[i] on tick to sync2 only when sync2==h1==h0 (three consecutive equal samples); otherwise hold.
REQ-020 SHALL, with cfg_deb_en[i]=0, register gpio_data_in[i]<=sync2 every cycle; history keeps shifting regardless of cfg_deb_en.
REQ-021 SHALL keep prev_in register: prev_in<=gpio_data_in every cycle.
REQ-022 SHALL compute event[i] = (posedge_sel & ~prev_in & gpio_data_in) | (negedge_sel & prev_in & ~gpio_data_in); both selects set = both edges.
REQ-023 SHALL set gpio_int_sts[i] on the edge after event[i]; SHALL clear it on the edge after sts_clr[i]=1.
REQ-024 SHALL give set priority over clear when event[i] and sts_clr[i] coincide (status stays 1).
REQ-025 SHALL set status regardless of cfg_int_mask; mask gates only gpio_irq.
REQ-026 SHALL register gpio_irq <= |(gpio_int_sts & cfg_int_mask), one cycle after status/mask change.
REQ-027 SHALL meet latency, debounce off, pad change before edge E: sync2 at E+1, gpio_data_in at E+2, gpio_int_sts at E+3, gpio_irq at E+4.
REQ-028 SHALL reject with debounce on any pulse shorter than 3 ticks; glitch between ticks SHALL be invisible.

Reset
REQ-029 SHALL, while h_reset=1 at an edge, clear sync1, sync2, history, prescaler, gpio_data_in, prev_in, gpio_int_sts, gpio_irq to 0.
REQ-030 SHALL allow a pad held high through reset to raise a rising event after reset if posedge_sel=1 (prev_in starts 0).
REQ-031 SHALL abandon mid-count debounce and pending status on reset; no event generated by reset itself.

Verification
REQ-032 Debounce off, posedge_sel[3]=1, mask[3]=1, pad[3] 0->1 before edge E -> gpio_data_in[3]=1 at E+2, sts[3]=1 at E+3, gpio_irq=1 at E+4.
REQ-033 Debounce on, presc=3, pad[0] high 8 cycles then low -> no change of gpio_data_in[0]; high 12+ cycles -> gpio_data_in[0]=1 after third equal tick.
REQ-034 sts[5]=1, sts_clr[5]=1 same cycle as new event[5] -> sts[5] stays 1; sts_clr[5] alone next -> sts[5]=0, gpio_irq=0 one cycle later.
REQ-035 mask=0, negedge_sel[7]=1, pad[7] 1->0 -> sts[7]=1, gpio_irq=0; then mask[7]=1 -> gpio_irq=1 next cycle.
REQ-036 presc=0xFFFF, counter at 0x0100, presc written 0x0010 -> tick next cycle, then period 17 cycles.
REQ-037 h_reset asserted mid-debounce with sts=0xFFFF_FFFF -> all outputs 0 after the reset edge; counter restarts from 0.

Source files
------------

// File: rtl/gpio_intr_ctrl_if.sv
// GPIO interrupt controller signal bundle.
// Master drives pads, config and clear strobes; slave returns pin state.
interface gpio_intr_ctrl_if #(
  parameter int NPIN    = 32,
  parameter int PRESC_W = 16
);
  logic [NPIN-1:0]    pad_gpio_in;
  logic [NPIN-1:0]    cfg_deb_en;
  logic [PRESC_W-1:0] cfg_deb_presc;
  logic [NPIN-1:0]    cfg_posedge_sel;
  logic [NPIN-1:0]    cfg_negedge_sel;
  logic [NPIN-1:0]    cfg_int_mask;
  logic [NPIN-1:0]    sts_clr;
  logic [NPIN-1:0]    gpio_data_in;
  logic [NPIN-1:0]    gpio_int_sts;
  logic               gpio_irq;

  modport master (
    output pad_gpio_in,
    output cfg_deb_en,
    output cfg_deb_presc,
    output cfg_posedge_sel,
    output cfg_negedge_sel,
    output cfg_int_mask,
    output sts_clr,
    input  gpio_data_in,
    input  gpio_int_sts,
    input  gpio_irq
  );

  modport slave (
    input  pad_gpio_in,
    input  cfg_deb_en,
    input  cfg_deb_presc,
    input  cfg_posedge_sel,
    input  cfg_negedge_sel,
    input  cfg_int_mask,
    input  sts_clr,
    output gpio_data_in,
    output gpio_int_sts,
    output gpio_irq
  );
endinterface

// File: rtl/gpio_intr_ctrl.sv
// GPIO input synchroniser, shared-prescaler debouncer and
// edge-detecting sticky interrupt status with masked irq.
module gpio_intr_ctrl #(
  parameter int NPIN    = 32,
  parameter int PRESC_W = 16
) (
  input logic mclk,
  input logic h_reset,
  gpio_intr_ctrl_if.slave bus
);

  logic [NPIN-1:0]    sync1;
  logic [NPIN-1:0]    sync2;
  logic [NPIN-1:0]    h1;
  logic [NPIN-1:0]    h0;
  logic [NPIN-1:0]    data;
  logic [NPIN-1:0]    prev_in;
  logic [NPIN-1:0]    sts;
  logic [NPIN-1:0]    evt;
  logic [NPIN-1:0]    stable;
  logic [NPIN-1:0]    upd;
  logic [PRESC_W-1:0] cnt;
  logic               tick;
  logic               irq;

  // >= compare so a lowered period never strands the counter
  assign tick = (cnt >= bus.cfg_deb_presc);

  // three equal samples: current sync2 plus two tick history bits
  assign stable = ~(sync2 ^ h1) & ~(h1 ^ h0);

  // unfiltered pins follow every cycle, filtered ones on stable tick
  assign upd = ~bus.cfg_deb_en | ({NPIN{tick}} & stable);

  assign evt = (bus.cfg_posedge_sel & ~prev_in & data)
             | (bus.cfg_negedge_sel & prev_in & ~data);

  // two-flop synchroniser on raw pads
  always_ff @(posedge mclk) begin
    if (h_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.pad_gpio_in;
      sync2 <= sync1;
    end
  end

  // shared debounce prescaler
  always_ff @(posedge mclk) begin
    if (h_reset) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  // tick-sampled history, shifts independent of debounce enable
  always_ff @(posedge mclk) begin
    if (h_reset) begin
      h1 <= '0;
      h0 <= '0;
    end else if (tick) begin
      h1 <= sync2;
      h0 <= h1;
    end
  end

  // filtered pin value and its one-cycle-old copy for edge detect
  always_ff @(posedge mclk) begin
    if (h_reset) begin
      data    <= '0;
      prev_in <= '0;
    end else begin
      data    <= (data & ~upd) | (sync2 & upd);
      prev_in <= data;
    end
  end

  // sticky status, a fresh event wins over a clear
  always_ff @(posedge mclk) begin
    if (h_reset) sts <= '0;
    else sts <= (sts & ~bus.sts_clr) | evt;
  end

  // registered irq from masked status
  always_ff @(posedge mclk) begin
    if (h_reset) irq <= 1'b0;
    else irq <= |(sts & bus.cfg_int_mask);
  end

  assign bus.gpio_data_in = data;
  assign bus.gpio_int_sts = sts;
  assign bus.gpio_irq     = irq;

endmodule
